solver_dispatch: RTL
====================

Name: solver_dispatch

Overview:
- Sits directly upstream of the mandelbrot solver control/datapath and sequences one pixel job at a time into it.
- Accepts a job header (limb count, iteration limit, tag) plus a stream of c limbs.
- Programs the solver's configuration and c registers, pulses start, and waits for the solver's out_ready.
- Returns the iteration count, tagged, on a valid/ready result port.

Parameters:
- LIMB_INDEX_BITS, 6, width of limb count/index; matches solver.
- LIMB_BITS, 32, width of one c limb.
- TAG_BITS, 16, opaque pixel tag carried from job to result.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- job_valid  in  1  job header offered
- job_ready  out  1  dispatcher can accept header
- job_num_limbs  in  LIMB_INDEX_BITS  limbs per component
- job_iter_lim  in  16  iteration limit
- job_tag  in  TAG_BITS  pixel tag
- limb_valid  in  1  limb beat offered
- limb_ready  out  1  dispatcher accepts limb beat
- limb_data  in  LIMB_BITS  limb value
- wr_en  out  1  write c limb to solver
- wr_ind  out  1  0 = cre, 1 = cim
- wr_limb_ind  out  LIMB_INDEX_BITS  limb index being written
- wr_data  out  LIMB_BITS  limb value to solver
- wr_num_limbs_en  out  1  load solver limb count
- num_limbs_data  out  LIMB_INDEX_BITS  limb count to solver
- wr_iter_lim_en  out  1  load solver iteration limit
- iter_lim_data  out  16  iteration limit to solver
- start  out  1  one-cycle solve start pulse
- solver_out_ready  in  1  solver's out_ready
- solver_iteration_count  in  16  solver's iteration_count
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_tag  out  TAG_BITS  tag of finished job
- res_count  out  16  iteration count; 16'hFFFF = did not diverge
- res_err  out  1  job rejected (num_limbs == 0)
- busy  out  1  any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset, asynchronous: state = IDLE; every output is 0 except job_ready = 1. Latched num_limbs, iter_lim and tag clear to 0.
- States: IDLE, CFG, LOAD, START, WAIT_LOW, WAIT_DONE, RESULT.
- IDLE:
  - job_ready = 1.
  - On job_valid && job_ready, latch the header and drop job_ready next cycle.
  - If num_limbs == 0, go to RESULT with res_err = 1, res_count = 0. Otherwise go to CFG.
- CFG (1 cycle): wr_num_limbs_en = wr_iter_lim_en = 1, with the latched data driven on num_limbs_data and iter_lim_data. Next state is LOAD.
- LOAD:
  - limb_ready = 1.
  - Expects 2*num_limbs beats: cre limbs with index num_limbs-1 down to 0 (MSB first), then cim limbs in the same order.
  - Each accepted beat produces, on the following cycle, wr_en = 1, wr_ind, wr_limb_ind and wr_data = beat. wr_en is 0 when no beat was accepted.
  - A bubble on limb_valid inserts a bubble on wr_en; no limb is dropped or duplicated.
  - On acceptance of the last cim index-0 beat: limb_ready = 0 next cycle; go to START after the final write issues.
- START (1 cycle): start = 1. Next state is WAIT_LOW.
- WAIT_LOW: wait for solver_out_ready == 0. The solver drops it the cycle after start; if already 0, advance next cycle.
- WAIT_DONE: on solver_out_ready == 1, capture solver_iteration_count into res_count and set res_err = 0. Go to RESULT.
- RESULT:
  - res_valid = 1; res_tag, res_count and res_err are held stable.
  - On res_valid && res_ready, clear res_valid next cycle and return to IDLE; job_ready = 1 in that same cycle.
- Only one job is in flight. job_valid and limb_valid are ignored outside IDLE and LOAD respectively.
- Limb counter width is LIMB_INDEX_BITS+1 so that 2*num_limbs never wraps; num_limbs = 2^LIMB_INDEX_BITS - 1 must work.
- Simultaneous events:
  - res_ready held high: RESULT lasts exactly 1 cycle.
  - A new job_valid during RESULT waits for IDLE.
- Reset mid-operation (any state): immediate return to IDLE, and the in-flight job is discarded. No start pulse is issued after reset deasserts.

Test Plan:
- Basic job: num_limbs = 2, iter_lim = 100, tag = 5, limbs A,B,C,D back-to-back. Required: CFG pulse with 2/100; writes (0,1,A), (0,0,B), (1,1,C), (1,0,D); one start pulse. Solver model returns 37 → res_valid with tag 5, count 37, err 0.
- Limb stream bubbles: limb_valid toggles every other cycle. Required: 4 writes, in order, each exactly once; start only after the 4th write.
- num_limbs = 0, tag = 9. Required: no CFG/wr/start activity; res_valid with count 0, err 1.
- Non-divergent job: solver returns 16'hFFFF. Required: res_count = 16'hFFFF; res_ready held low 10 cycles keeps res_* stable and job_ready = 0.
- Reset asserted in WAIT_DONE. Required: all outputs 0 and job_ready = 1 asynchronously; a following job with num_limbs = 1 completes normally.
- Two back-to-back jobs with res_ready tied high. Required: second header accepted the cycle after the first RESULT; tags and counts are paired correctly.

Source files
------------

// File: rtl/solver_dispatch.sv
// Dispatcher that feeds one pixel job at a time into the mandelbrot solver:
// it takes a job header and a c-limb stream, programs the solver, starts it,
// waits for completion and returns the tagged iteration count.
module solver_dispatch #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32,
    parameter int TAG_BITS        = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [LIMB_INDEX_BITS-1:0] job_num_limbs,
    input  logic [15:0]                job_iter_lim,
    input  logic [TAG_BITS-1:0]        job_tag,
    input  logic                       limb_valid,
    output logic                       limb_ready,
    input  logic [LIMB_BITS-1:0]       limb_data,
    output logic                       wr_en,
    output logic                       wr_ind,
    output logic [LIMB_INDEX_BITS-1:0] wr_limb_ind,
    output logic [LIMB_BITS-1:0]       wr_data,
    output logic                       wr_num_limbs_en,
    output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
    output logic                       wr_iter_lim_en,
    output logic [15:0]                iter_lim_data,
    output logic                       start,
    input  logic                       solver_out_ready,
    input  logic [15:0]                solver_iteration_count,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TAG_BITS-1:0]        res_tag,
    output logic [15:0]                res_count,
    output logic                       res_err,
    output logic                       busy
);

    typedef enum logic [2:0] {
        IDLE, CFG, LOAD, START, WAIT_LOW, WAIT_DONE, RESULT
    } state_t;

    // Beat counter is one bit wider than the limb index so 2*num_limbs fits.
    localparam int CW = LIMB_INDEX_BITS + 1;
    localparam logic [CW-1:0]              ONE_C = {{LIMB_INDEX_BITS{1'b0}}, 1'b1};
    localparam logic [LIMB_INDEX_BITS-1:0] ONE_I = {{(LIMB_INDEX_BITS-1){1'b0}}, 1'b1};

    state_t state_q, state_n;

    logic [LIMB_INDEX_BITS-1:0] num_limbs_q, num_limbs_n;
    logic [TAG_BITS-1:0]        tag_q, tag_n;
    logic [CW-1:0]              cnt_q, cnt_n;
    logic [CW-1:0]              two_n;
    logic [LIMB_INDEX_BITS-1:0] cnt_lo;
    logic                       beat_acc;
    logic                       in_cre;

    logic                       job_ready_n, limb_ready_n;
    logic                       wr_en_n, wr_ind_n;
    logic [LIMB_INDEX_BITS-1:0] wr_limb_ind_n;
    logic [LIMB_BITS-1:0]       wr_data_n;
    logic                       wr_num_limbs_en_n, wr_iter_lim_en_n;
    logic [LIMB_INDEX_BITS-1:0] num_limbs_data_n;
    logic [15:0]                iter_lim_data_n;
    logic                       start_n;
    logic                       res_valid_n, res_err_n;
    logic [TAG_BITS-1:0]        res_tag_n;
    logic [15:0]                res_count_n;
    logic                       busy_n;

    assign two_n    = {num_limbs_q, 1'b0};
    assign cnt_lo   = cnt_q[LIMB_INDEX_BITS-1:0];
    assign beat_acc = (state_q == LOAD) && limb_valid && limb_ready;
    assign in_cre   = (cnt_q < {1'b0, num_limbs_q});

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n           = state_q;
        num_limbs_n       = num_limbs_q;
        tag_n             = tag_q;
        cnt_n             = cnt_q;
        job_ready_n       = job_ready;
        limb_ready_n      = limb_ready;
        wr_en_n           = 1'b0;
        wr_ind_n          = wr_ind;
        wr_limb_ind_n     = wr_limb_ind;
        wr_data_n         = wr_data;
        wr_num_limbs_en_n = 1'b0;
        wr_iter_lim_en_n  = 1'b0;
        num_limbs_data_n  = num_limbs_data;
        iter_lim_data_n   = iter_lim_data;
        start_n           = 1'b0;
        res_valid_n       = res_valid;
        res_err_n         = res_err;
        res_tag_n         = res_tag;
        res_count_n       = res_count;

        case (state_q)
            IDLE: begin
                if (job_valid && job_ready) begin
                    num_limbs_n = job_num_limbs;
                    tag_n       = job_tag;
                    cnt_n       = '0;
                    job_ready_n = 1'b0;
                    if (job_num_limbs == '0) begin
                        state_n     = RESULT;
                        res_valid_n = 1'b1;
                        res_err_n   = 1'b1;
                        res_count_n = '0;
                        res_tag_n   = job_tag;
                    end else begin
                        state_n           = CFG;
                        wr_num_limbs_en_n = 1'b1;
                        wr_iter_lim_en_n  = 1'b1;
                        num_limbs_data_n  = job_num_limbs;
                        iter_lim_data_n   = job_iter_lim;
                    end
                end
            end
            CFG: begin
                state_n      = LOAD;
                limb_ready_n = 1'b1;
            end
            LOAD: begin
                // limb_ready drops after the last beat; the cycle carrying the
                // final write then sees cnt == 2n and hands over to START.
                if (beat_acc) begin
                    wr_en_n   = 1'b1;
                    wr_data_n = limb_data;
                    if (in_cre) begin
                        wr_ind_n      = 1'b0;
                        wr_limb_ind_n = num_limbs_q - cnt_lo - ONE_I;
                    end else begin
                        wr_ind_n      = 1'b1;
                        wr_limb_ind_n = num_limbs_q + num_limbs_q - cnt_lo - ONE_I;
                    end
                    cnt_n = cnt_q + ONE_C;
                    if (cnt_q == two_n - ONE_C) begin
                        limb_ready_n = 1'b0;
                    end
                end else if (cnt_q == two_n) begin
                    state_n = START;
                    start_n = 1'b1;
                end
            end
            START: begin
                state_n = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!solver_out_ready) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (solver_out_ready) begin
                    state_n     = RESULT;
                    res_valid_n = 1'b1;
                    res_err_n   = 1'b0;
                    res_count_n = solver_iteration_count;
                    res_tag_n   = tag_q;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_n     = IDLE;
                    res_valid_n = 1'b0;
                    job_ready_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State, latched job header, beat counter and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            num_limbs_q     <= '0;
            tag_q           <= '0;
            cnt_q           <= '0;
            job_ready       <= 1'b1;
            limb_ready      <= 1'b0;
            wr_en           <= 1'b0;
            wr_ind          <= 1'b0;
            wr_limb_ind     <= '0;
            wr_data         <= '0;
            wr_num_limbs_en <= 1'b0;
            num_limbs_data  <= '0;
            wr_iter_lim_en  <= 1'b0;
            iter_lim_data   <= '0;
            start           <= 1'b0;
            res_valid       <= 1'b0;
            res_tag         <= '0;
            res_count       <= '0;
            res_err         <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_n;
            num_limbs_q     <= num_limbs_n;
            tag_q           <= tag_n;
            cnt_q           <= cnt_n;
            job_ready       <= job_ready_n;
            limb_ready      <= limb_ready_n;
            wr_en           <= wr_en_n;
            wr_ind          <= wr_ind_n;
            wr_limb_ind     <= wr_limb_ind_n;
            wr_data         <= wr_data_n;
            wr_num_limbs_en <= wr_num_limbs_en_n;
            num_limbs_data  <= num_limbs_data_n;
            wr_iter_lim_en  <= wr_iter_lim_en_n;
            iter_lim_data   <= iter_lim_data_n;
            start           <= start_n;
            res_valid       <= res_valid_n;
            res_tag         <= res_tag_n;
            res_count       <= res_count_n;
            res_err         <= res_err_n;
            busy            <= busy_n;
        end
    end

endmodule
